// File: rtl/icache_nway_mem.sv
// icache_nway_mem: N-way set-associative instruction-cache tag/data store.
//
// Lookups are combinational on rd_pc_reg. Fills from the fill controller are written at the
// rising clock edge and become visible one cycle later. Replacement prefers an existing
// matching tag, then the lowest invalid way, then the tree-PLRU victim. A flush_req pulse
// starts a sweep that invalidates one set per cycle. Fills and hits are blocked while it runs.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   wr_en/wr_data/wr_pc_reg  fill request, line data and line address
//   wr_ready              fills accepted (low during the flush sweep)
//   rd_pc_reg             lookup address
//   rd_data/rd_valid/rd_way  hit data, hit flag and hit way (all zero on miss)
//   flush_req/flush_busy  invalidate-all request pulse and sweep-in-progress flag
module icache_nway_mem #(
  parameter int unsigned NUM_SETS    = 64,
  parameter int unsigned NUM_WAYS    = 4,
  parameter int unsigned LINE_BITS   = 64,
  parameter int unsigned ADDR_BITS   = 64,
  parameter int unsigned OFFSET_BITS = 3,
  localparam int unsigned IDX_BITS   = $clog2(NUM_SETS),
  localparam int unsigned TAG_BITS   = ADDR_BITS - IDX_BITS - OFFSET_BITS,
  localparam int unsigned WAY_BITS   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [LINE_BITS-1:0] wr_data,
  input  logic [ADDR_BITS-1:0] wr_pc_reg,
  output logic                 wr_ready,
  input  logic [ADDR_BITS-1:0] rd_pc_reg,
  output logic [LINE_BITS-1:0] rd_data,
  output logic                 rd_valid,
  output logic [WAY_BITS-1:0]  rd_way,
  input  logic                 flush_req,
  output logic                 flush_busy
);

  localparam int unsigned LEVELS    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 0;
  localparam int unsigned PLRU_BITS = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StSweep = 1'b1;

  // Storage. Tag and data arrays carry no reset; valid bits gate every use of them.
  logic [TAG_BITS-1:0]  tag_q   [NUM_SETS][NUM_WAYS];
  logic [LINE_BITS-1:0] data_q  [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];
  logic [PLRU_BITS-1:0] plru_q  [NUM_SETS];

  logic [0:0]          state_q, state_d;
  logic [IDX_BITS-1:0] cnt_q, cnt_d;

  logic [IDX_BITS-1:0] rd_idx, wr_idx;
  logic [TAG_BITS-1:0] rd_tag, wr_tag;

  logic                 rd_hit;
  logic [WAY_BITS-1:0]  rd_hit_way;
  logic [LINE_BITS-1:0] rd_hit_data;

  logic                wr_match, wr_inv_found, fill;
  logic [WAY_BITS-1:0] wr_match_way, wr_inv_way, fill_way;
  logic                sweeping;

  logic unused_offset_bits;

  // PLRU heap layout: node 0 is the root, node n has children 2n+1 (lower half) and 2n+2.
  // A node bit of 0 means the LRU side is the lower half.
  function automatic logic [PLRU_BITS-1:0] plru_touch(input logic [PLRU_BITS-1:0] bits_in,
                                                      input logic [WAY_BITS-1:0]  way);
    logic [PLRU_BITS-1:0] bits;
    int                   wi;
    bits = bits_in;
    wi   = int'(way);
    for (int l = 0; l < int'(LEVELS); l++) begin
      for (int k = 0; k < (1 << l); k++) begin
        // Node k of level l lies on the way's path when the way's top l bits equal k.
        if ((wi >> (int'(LEVELS) - l)) == k) begin
          bits[(1 << l) - 1 + k] = ~wi[int'(LEVELS) - 1 - l];
        end
      end
    end
    return bits;
  endfunction

  function automatic logic [WAY_BITS-1:0] plru_victim(input logic [PLRU_BITS-1:0] bits);
    int   v;
    logic b;
    v = 0;
    for (int l = 0; l < int'(LEVELS); l++) begin
      b = 1'b0;
      for (int k = 0; k < (1 << l); k++) begin
        if (v == k) b = bits[(1 << l) - 1 + k];
      end
      v = 2 * v + (b ? 1 : 0);
    end
    return WAY_BITS'(v);
  endfunction

  assign rd_idx = rd_pc_reg[OFFSET_BITS +: IDX_BITS];
  assign rd_tag = rd_pc_reg[ADDR_BITS-1 -: TAG_BITS];
  assign wr_idx = wr_pc_reg[OFFSET_BITS +: IDX_BITS];
  assign wr_tag = wr_pc_reg[ADDR_BITS-1 -: TAG_BITS];

  assign unused_offset_bits = ^{rd_pc_reg[OFFSET_BITS-1:0], wr_pc_reg[OFFSET_BITS-1:0]};

  assign sweeping   = (state_q == StSweep);
  assign flush_busy = sweeping;
  assign wr_ready   = ~sweeping;
  assign fill       = wr_en & wr_ready;

  // Lookup. Fills never create duplicate tags, so at most one way matches.
  always_comb begin
    rd_hit      = 1'b0;
    rd_hit_way  = '0;
    rd_hit_data = '0;
    for (int w = 0; w < int'(NUM_WAYS); w++) begin
      if (valid_q[rd_idx][w] && (tag_q[rd_idx][w] == rd_tag)) begin
        rd_hit      = 1'b1;
        rd_hit_way  = WAY_BITS'(w);
        rd_hit_data = data_q[rd_idx][w];
      end
    end
  end

  assign rd_valid = rd_hit & ~sweeping;
  assign rd_data  = rd_valid ? rd_hit_data : '0;
  assign rd_way   = rd_valid ? rd_hit_way : '0;

  // Fill way selection: existing tag, else lowest invalid way, else PLRU victim.
  always_comb begin
    wr_match     = 1'b0;
    wr_match_way = '0;
    wr_inv_found = 1'b0;
    wr_inv_way   = '0;
    for (int w = 0; w < int'(NUM_WAYS); w++) begin
      if (valid_q[wr_idx][w] && (tag_q[wr_idx][w] == wr_tag)) begin
        wr_match     = 1'b1;
        wr_match_way = WAY_BITS'(w);
      end
    end
    // Descending scan so the lowest invalid way is the last one recorded.
    for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
      if (!valid_q[wr_idx][w]) begin
        wr_inv_found = 1'b1;
        wr_inv_way   = WAY_BITS'(w);
      end
    end
    if (wr_match) begin
      fill_way = wr_match_way;
    end else if (wr_inv_found) begin
      fill_way = wr_inv_way;
    end else begin
      fill_way = plru_victim(plru_q[wr_idx]);
    end
  end

  // Flush sweep control.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (state_q == StIdle) begin
      if (flush_req) state_d = StSweep;
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == IDX_BITS'(NUM_SETS - 1)) state_d = StIdle;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      for (int s = 0; s < int'(NUM_SETS); s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (sweeping) begin
        valid_q[cnt_q] <= '0;
        plru_q[cnt_q]  <= '0;
      end else begin
        if (rd_hit) begin
          plru_q[rd_idx] <= plru_touch(plru_q[rd_idx], rd_hit_way);
        end
        // Placed after the hit update so a fill to the same set takes precedence.
        if (fill) begin
          valid_q[wr_idx][fill_way] <= 1'b1;
          plru_q[wr_idx]            <= plru_touch(plru_q[wr_idx], fill_way);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (fill) begin
      tag_q[wr_idx][fill_way]  <= wr_tag;
      data_q[wr_idx][fill_way] <= wr_data;
    end
  end

endmodule

// File: tb/tb_icache_nway_mem.sv
`timescale 1ns/1ps
module tb_icache_nway_mem;

  localparam logic [63:0] DA = 64'hA0A0_0000_0000_000A;
  localparam logic [63:0] DB = 64'hB0B0_0000_0000_000B;
  localparam logic [63:0] DC = 64'hC0C0_0000_0000_000C;
  localparam logic [63:0] DD = 64'hD0D0_0000_0000_000D;
  localparam logic [63:0] DE = 64'hE0E0_0000_0000_000E;
  localparam logic [63:0] DF = 64'hF0F0_0000_0000_000F;
  localparam logic [63:0] DG = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] DX = 64'h5555_AAAA_5555_AAAA;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [63:0] wr_data = '0;
  logic [63:0] wr_pc_reg = '0;
  logic        wr_ready;
  logic [63:0] rd_pc_reg = 64'h200;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic [1:0]  rd_way;
  logic        flush_req = 1'b0;
  logic        flush_busy;

  always #5 clock = ~clock;

  icache_nway_mem #(
    .NUM_SETS   (64),
    .NUM_WAYS   (4),
    .LINE_BITS  (64),
    .ADDR_BITS  (64),
    .OFFSET_BITS(3)
  ) u_dut (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_pc_reg (wr_pc_reg),
    .wr_ready  (wr_ready),
    .rd_pc_reg (rd_pc_reg),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_way    (rd_way),
    .flush_req (flush_req),
    .flush_busy(flush_busy)
  );

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
    logic [1:0]  way;
    logic        busy;
    logic        ready;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  exp_t  mon_e;
  exp_t  mon_got;
  string mon_n;

  // Monitor: one expectation is queued per lookup cycle; compare away from the active edge.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_n   = name_q.pop_front();
      mon_got = {rd_valid, rd_data, rd_way, flush_busy, wr_ready};
      n_cmp++;
      if (mon_got !== mon_e) begin
        n_fail++;
        $display("FAIL %s: got valid=%0b data=%h way=%0d busy=%0b ready=%0b, want valid=%0b data=%h way=%0d busy=%0b ready=%0b",
                 mon_n, mon_got.valid, mon_got.data, mon_got.way, mon_got.busy, mon_got.ready,
                 mon_e.valid, mon_e.data, mon_e.way, mon_e.busy, mon_e.ready);
      end
    end
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic look(input logic [63:0] pc, input logic v, input logic [63:0] d,
                      input logic [1:0] w, input logic busy, input logic rdy, input string n);
    exp_t e;
    e.valid = v;
    e.data  = d;
    e.way   = w;
    e.busy  = busy;
    e.ready = rdy;
    rd_pc_reg = pc;
    exp_q.push_back(e);
    name_q.push_back(n);
    cycle();
  endtask

  task automatic hit(input logic [63:0] pc, input logic [63:0] d, input logic [1:0] w,
                     input string n);
    look(pc, 1'b1, d, w, 1'b0, 1'b1, n);
  endtask

  task automatic miss(input logic [63:0] pc, input string n);
    look(pc, 1'b0, 64'h0, 2'd0, 1'b0, 1'b1, n);
  endtask

  task automatic fill(input logic [63:0] pc, input logic [63:0] d);
    wr_en     = 1'b1;
    wr_pc_reg = pc;
    wr_data   = d;
    cycle();
    wr_en     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state, observed while reset is held low.
    cycle();
    miss(64'h200, "reset_state");
    reset = 1'b1;
    cycle();

    // Same-cycle read of the line being filled sees the old (empty) contents.
    wr_en = 1'b1; wr_pc_reg = 64'h200; wr_data = DA;
    miss(64'h200, "same_cycle_read_old");
    wr_en = 1'b0;
    hit(64'h200, DA, 2'd0, "fill_visible_next_cycle");

    // Set 0 fills land in ways 1..3 in order.
    fill(64'h400, DB);
    fill(64'h600, DC);
    fill(64'h800, DD);
    hit(64'h400, DB, 2'd1, "read_0x400_way1");

    // Hits in order 2,0,1: root points to the upper half, node 2 to way 3 -> victim way 3.
    hit(64'h600, DC, 2'd2, "hit_way2");
    hit(64'h200, DA, 2'd0, "hit_way0");
    hit(64'h400, DB, 2'd1, "hit_way1");
    fill(64'hA00, DX);
    miss(64'h800, "plru_evicted_0x800");
    hit(64'hA00, DX, 2'd3, "victim_way3");

    // Refill of a present tag overwrites in place; the other ways keep their own tags.
    fill(64'h400, DE);
    hit(64'h400, DE, 2'd1, "refill_same_way");
    hit(64'h200, DA, 2'd0, "refill_keeps_way0");
    hit(64'h600, DC, 2'd2, "refill_keeps_way2");
    hit(64'hA00, DX, 2'd3, "refill_keeps_way3");

    // Line in set 63 (tag 1).
    fill(64'h3F8, DF);
    hit(64'h3F8, DF, 2'd0, "set63_fill");

    // Flush sweep: exactly 64 busy cycles; held fill and a repeated flush_req are ignored.
    flush_req = 1'b1;
    cycle();
    flush_req = 1'b0;
    wr_en = 1'b1; wr_pc_reg = 64'h5F8; wr_data = DG;
    for (int i = 0; i < 64; i++) begin
      flush_req = (i == 20);
      look(64'h3F8, 1'b0, 64'h0, 2'd0, 1'b1, 1'b0, "sweep_busy");
    end
    flush_req = 1'b0;
    wr_en = 1'b0;
    miss(64'h5F8, "sweep_fill_ignored");
    miss(64'h3F8, "flushed_set63");
    miss(64'h200, "flushed_set0_a");
    miss(64'hA00, "flushed_set0_b");
    miss(64'h400, "flushed_set0_c");

    // Reset asserted at cycle 10 of a sweep aborts it; set 63 is cleared by reset alone.
    fill(64'h3F8, DF);
    fill(64'h200, DA);
    hit(64'h3F8, DF, 2'd0, "prefill_set63");
    flush_req = 1'b1;
    cycle();
    flush_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      look(64'h3F8, 1'b0, 64'h0, 2'd0, 1'b1, 1'b0, "sweep2_busy");
    end
    reset = 1'b0;
    #1;
    look(64'h3F8, 1'b0, 64'h0, 2'd0, 1'b0, 1'b1, "reset_aborts_sweep");
    reset = 1'b1;
    miss(64'h3F8, "after_reset_set63");
    miss(64'h200, "after_reset_set0");
    fill(64'h600, DC);
    hit(64'h600, DC, 2'd0, "post_reset_fill");

    cycle();
    cycle();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
